// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug monitor: LED page encoding,
// LED nibble width, heartbeat width and a nibble-select helper.
package dbg_pkg;

    localparam int LED_W = 4;
    localparam int HB_W  = 26;

    typedef enum logic [3:0] {
        PG_HB     = 4'd0,
        PG_STICKY = 4'd1,
        PG_CNT    = 4'd2,
        PG_HOLD   = 4'd3,
        PG_SNAP   = 4'd4,
        PG_EV     = 4'd5,
        PG_STAT   = 4'd6
    } dbg_page_e;

    // Pick nibble idx out of a 32-bit word; idx 7 is the top nibble.
    function automatic logic [LED_W-1:0] nib_sel(input logic [31:0] vec,
                                                 input logic [2:0]  idx);
        return vec[{idx, 2'b00} +: LED_W];
    endfunction

endpackage

// File: rtl/dbg_monitor_if.sv
// Instruction-commit bus observed by the debug monitor.
interface dbg_monitor_if;

    logic        commit_valid_i;
    logic [31:0] commit_pc_i;

    modport master (output commit_valid_i, output commit_pc_i);
    modport slave  (input  commit_valid_i, input  commit_pc_i);

endinterface

// File: rtl/dbg_evt_counter.sv
// One event channel: counter with wrap or saturate, sticky-seen and
// overflow/saturation flags. Clear beats events; freeze holds everything.
module dbg_evt_counter #(
    parameter int CNT_W = 32,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             freeze_i,
    input  logic             ev_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sticky_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             sat_q, sat_d;

    // Next-state: clear, else count an event unless frozen.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        sat_d    = sat_q;
        if (clr_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
            sat_d    = 1'b0;
        end else if (ev_i && !freeze_i) begin
            sticky_d = 1'b1;
            if (&cnt_q) begin
                sat_d = 1'b1;
                cnt_d = (SAT != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            sat_q    <= sat_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign sticky_o = sticky_q;
    assign sat_o    = sat_q;

endmodule

// File: rtl/dbg_monitor.sv
// Debug monitor: per-channel event statistics, PC tracking (last, sampled
// with hold-off, snapshot) and a sticky completion flag, all viewable one
// nibble at a time on a registered LED output selected by page/index.
module dbg_monitor
    import dbg_pkg::*;
#(
    parameter int          NUM_EV    = 8,
    parameter int          CNT_W     = 32,
    parameter int          CNT_SHIFT = 14,
    parameter int          SAT       = 0,
    parameter int          HOLD_W    = 24,
    parameter logic [31:0] DONE_PC   = 32'h0000_0694
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_EV-1:0] ev_i,
    dbg_monitor_if.slave      commit_if,
    input  logic [3:0]        page_sel_i,
    input  logic [2:0]        idx_sel_i,
    input  logic              snap_req_i,
    input  logic              clr_i,
    input  logic              freeze_i,
    output logic [LED_W-1:0]  led_o,
    output logic              done_o
);

    localparam logic [31:0] DONE_PC_ALT = DONE_PC + 32'd4;

    logic              commit_valid;
    logic [31:0]       commit_pc;

    logic [HB_W-1:0]   hb_q, hb_d;
    logic [31:0]       pc_last_q, pc_last_d;
    logic [31:0]       pc_snap_q, pc_snap_d;
    logic [3:0]        pc_hold_nib_q, pc_hold_nib_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        idx_q, idx_d;
    logic              snap_req_q, snap_req_d;
    logic              done_q, done_d;
    logic [LED_W-1:0]  led_q, led_d;

    logic              snap_trig;
    logic [NUM_EV-1:0] sticky;
    logic [NUM_EV-1:0] sat;
    logic [LED_W-1:0]  cnt_nib [NUM_EV];
    logic [LED_W-1:0]  cnt_sel;
    logic [31:0]       sticky_ext;
    logic [31:0]       sat_ext;
    logic [31:0]       ev_ext;

    assign commit_valid = commit_if.commit_valid_i;
    assign commit_pc    = commit_if.commit_pc_i;

    for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt;

        dbg_evt_counter #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr_i),
            .freeze_i (freeze_i),
            .ev_i     (ev_i[gi]),
            .cnt_o    (cnt),
            .sticky_o (sticky[gi]),
            .sat_o    (sat[gi])
        );

        assign cnt_nib[gi] = LED_W'(cnt >> CNT_SHIFT);
    end

    // Channels beyond NUM_EV read as zero through the padding.
    assign sticky_ext = 32'(sticky);
    assign sat_ext    = 32'(sat);
    assign ev_ext     = 32'(ev_i);

    assign snap_trig = (idx_sel_i != idx_q) || (snap_req_i && !snap_req_q);

    // PC tracking, hold-off sampler, edge detectors, heartbeat and done flag.
    always_comb begin
        hb_d          = hb_q + HB_W'(1);
        idx_d         = idx_sel_i;
        snap_req_d    = snap_req_i;
        pc_last_d     = pc_last_q;
        pc_snap_d     = pc_snap_q;
        pc_hold_nib_d = pc_hold_nib_q;
        hold_d        = hold_q;
        done_d        = done_q;
        if (clr_i) begin
            pc_last_d     = '0;
            pc_snap_d     = '0;
            pc_hold_nib_d = '0;
            hold_d        = '0;
            done_d        = 1'b0;
        end else begin
            // Snapshot takes pc_last before any same-cycle commit lands.
            if (snap_trig && !freeze_i) pc_snap_d = pc_last_q;
            if (commit_valid && !freeze_i) pc_last_d = commit_pc;
            if (hold_q == '0) begin
                if (commit_valid) begin
                    pc_hold_nib_d = commit_pc[5:2];
                    hold_d        = '1;
                end
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
            if (commit_valid && (commit_pc == DONE_PC || commit_pc == DONE_PC_ALT))
                done_d = 1'b1;
        end
    end

    // LED page mux, registered below for a fixed one-cycle latency.
    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            if (int'(idx_sel_i) == i) cnt_sel = cnt_nib[i];
        end
        case (dbg_page_e'(page_sel_i))
            PG_HB:     led_d = hb_q[HB_W-1 -: LED_W];
            PG_STICKY: led_d = nib_sel(sticky_ext, idx_sel_i);
            PG_CNT:    led_d = cnt_sel;
            PG_HOLD:   led_d = pc_hold_nib_q;
            PG_SNAP:   led_d = nib_sel(pc_snap_q, idx_sel_i);
            PG_EV:     led_d = nib_sel(ev_ext, idx_sel_i);
            PG_STAT:   led_d = {done_q, |sticky, sat_ext[{2'b00, idx_sel_i}], freeze_i};
            default:   led_d = '0;
        endcase
    end

    // Monitor state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_q          <= '0;
            pc_last_q     <= '0;
            pc_snap_q     <= '0;
            pc_hold_nib_q <= '0;
            hold_q        <= '0;
            idx_q         <= '0;
            snap_req_q    <= 1'b0;
            done_q        <= 1'b0;
            led_q         <= '0;
        end else begin
            hb_q          <= hb_d;
            pc_last_q     <= pc_last_d;
            pc_snap_q     <= pc_snap_d;
            pc_hold_nib_q <= pc_hold_nib_d;
            hold_q        <= hold_d;
            idx_q         <= idx_d;
            snap_req_q    <= snap_req_d;
            done_q        <= done_d;
            led_q         <= led_d;
        end
    end

    assign led_o  = led_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_dbg_monitor.sv
// Bench for dbg_monitor: a saturating and a wrapping instance share all
// stimulus; expectations come from an event-count / cycle-stamp model.
module tb_dbg_monitor;

    localparam int HOLD_SPAN = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ev;
    logic [3:0]  page;
    logic [2:0]  idx;
    logic        snap, clr, frz;
    logic [3:0]  led_a, led_b;
    logic        done_a, done_b;

    dbg_monitor_if cif ();

    always #5 clk = ~clk;

    dbg_monitor #(.NUM_EV(8), .CNT_W(4), .CNT_SHIFT(0), .SAT(1), .HOLD_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .ev_i(ev), .commit_if(cif),
        .page_sel_i(page), .idx_sel_i(idx), .snap_req_i(snap), .clr_i(clr),
        .freeze_i(frz), .led_o(led_a), .done_o(done_a));

    dbg_monitor #(.NUM_EV(8), .CNT_W(4), .CNT_SHIFT(0), .SAT(0), .HOLD_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ev_i(ev), .commit_if(cif),
        .page_sel_i(page), .idx_sel_i(idx), .snap_req_i(snap), .clr_i(clr),
        .freeze_i(frz), .led_o(led_b), .done_o(done_b));

    // Model: events seen per channel since clear, stamps instead of timers.
    int          n [8];
    bit          stk [8];
    logic [31:0] m_pc_last, m_pc_snap, m_hb;
    logic [3:0]  m_hold_nib;
    int          m_cyc, m_last_cap;
    bit          m_done, m_snap_prev;
    logic [2:0]  m_idx_prev;

    int compared = 0;
    int mismatched = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin n[i] = 0; stk[i] = 0; end
        m_pc_last = '0; m_pc_snap = '0; m_hb = '0; m_hold_nib = '0;
        m_cyc = 0; m_last_cap = -1; m_done = 0; m_snap_prev = 0; m_idx_prev = '0;
    endtask

    function automatic logic [3:0] cnt_of(input int cnt_n, input bit sat_mode);
        if (sat_mode) return (cnt_n > 15) ? 4'hF : 4'(cnt_n);
        return 4'(cnt_n % 16);
    endfunction

    function automatic logic [3:0] exp_led(input bit sat_mode);
        logic [31:0] sv;
        logic [31:0] evv;
        bit any;
        int ix;
        ix = int'(idx);
        sv = '0;
        any = 0;
        for (int i = 0; i < 8; i++) begin sv[i] = stk[i]; any = any | stk[i]; end
        evv = {24'h0, ev};
        case (page)
            4'd0: return m_hb[25:22];
            4'd1: return 4'(sv >> (4 * ix));
            4'd2: return cnt_of(n[ix], sat_mode);
            4'd3: return m_hold_nib;
            4'd4: return 4'(m_pc_snap >> (4 * ix));
            4'd5: return 4'(evv >> (4 * ix));
            4'd6: return {m_done, any, (n[ix] >= 16), frz};
            default: return 4'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] e, input bit cv, input logic [31:0] pc,
                        input logic [3:0] pg, input logic [2:0] ix, input bit sn,
                        input bit cl, input bit fz);
        logic [3:0] ea, eb;
        bit trig;
        ev = e; cif.commit_valid_i = cv; cif.commit_pc_i = pc;
        page = pg; idx = ix; snap = sn; clr = cl; frz = fz;
        ea = exp_led(1'b1);
        eb = exp_led(1'b0);
        trig = (ix != m_idx_prev) || (sn && !m_snap_prev);
        m_idx_prev = ix;
        m_snap_prev = sn;
        m_hb = m_hb + 1;
        if (cl) begin
            for (int i = 0; i < 8; i++) begin n[i] = 0; stk[i] = 0; end
            m_pc_last = '0; m_pc_snap = '0; m_hold_nib = '0; m_last_cap = -1; m_done = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (e[i] && !fz) begin stk[i] = 1; n[i] = n[i] + 1; end
            end
            if (trig && !fz) m_pc_snap = m_pc_last;
            if (cv && !fz) m_pc_last = pc;
            if (cv && (m_last_cap < 0 || m_cyc - m_last_cap >= HOLD_SPAN)) begin
                m_hold_nib = pc[5:2];
                m_last_cap = m_cyc;
            end
            if (cv && (pc == 32'h694 || pc == 32'h698)) m_done = 1;
        end
        m_cyc++;
        @(posedge clk);
        #1;
        check("led_sat", led_a, ea);
        check("led_wrap", led_b, eb);
        check("done_sat", {3'b0, done_a}, {3'b0, m_done});
        check("done_wrap", {3'b0, done_b}, {3'b0, m_done});
    endtask

    task automatic rand_step();
        logic [31:0] pc;
        int sel;
        sel = $urandom_range(7, 0);
        pc = (sel == 0) ? 32'h694 : (sel == 1) ? 32'h698 : $urandom;
        step(8'($urandom), ($urandom_range(1, 0) == 1), pc,
             4'($urandom_range(15, 0)), 3'($urandom_range(7, 0)),
             ($urandom_range(1, 0) == 1), ($urandom_range(31, 0) == 0),
             ($urandom_range(7, 0) == 0));
    endtask

    initial begin
        ev = '0; cif.commit_valid_i = 1'b0; cif.commit_pc_i = '0;
        page = '0; idx = '0; snap = 1'b0; clr = 1'b0; frz = 1'b0;
        model_reset();
        #3;
        check("rst_led_sat", led_a, 4'h0);
        check("rst_done_sat", {3'b0, done_a}, 4'h0);
        check("rst_led_wrap", led_b, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        step(8'h00, 0, 0, 4'd0, 3'd0, 0, 0, 0);
        // 16 pulses on channel 0, then status and count pages
        repeat (16) step(8'h01, 0, 0, 4'd6, 3'd0, 0, 0, 0);
        step(8'h00, 0, 0, 4'd6, 3'd0, 0, 0, 0);
        check("sat_bit_page6", {3'b0, led_a[1]}, 4'h1);
        step(8'h00, 0, 0, 4'd2, 3'd0, 0, 0, 0);
        check("cnt_sat_F", led_a, 4'hF);
        check("cnt_wrap_0", led_b, 4'h0);
        step(8'h01, 0, 0, 4'd2, 3'd0, 0, 0, 0);
        step(8'h00, 0, 0, 4'd2, 3'd0, 0, 0, 0);
        check("cnt_wrap_17", led_b, 4'h1);

        // completion PC, then clear racing an event and a commit
        step(8'h00, 1, 32'h698, 4'd6, 3'd0, 0, 0, 0);
        check("done_set", {3'b0, done_a}, 4'h1);
        step(8'hFF, 1, 32'h694, 4'd6, 3'd0, 0, 1, 0);
        check("done_clr", {3'b0, done_a}, 4'h0);
        step(8'h00, 0, 0, 4'd2, 3'd0, 0, 0, 0);
        check("cnt_clr", led_a, 4'h0);

        // hold-off sampler
        step(8'h00, 1, 32'h14, 4'd3, 3'd0, 0, 0, 0);
        step(8'h00, 0, 0, 4'd3, 3'd0, 0, 0, 0);
        step(8'h00, 1, 32'h28, 4'd3, 3'd0, 0, 0, 0);
        step(8'h00, 0, 0, 4'd3, 3'd0, 0, 0, 0);
        check("hold_nib_5", led_a, 4'h5);
        for (int k = 0; k < 20; k++) step(8'h00, 1, 32'h40 + 32'(4 * k), 4'd3, 3'd0, 0, 0, 0);

        // snapshot racing a commit, then a second request
        step(8'h00, 0, 0, 4'd4, 3'd7, 0, 0, 0);
        step(8'h00, 1, 32'h1234_5678, 4'd4, 3'd7, 1, 0, 0);
        step(8'h00, 0, 0, 4'd4, 3'd7, 0, 0, 0);
        step(8'h00, 0, 0, 4'd4, 3'd7, 1, 0, 0);
        step(8'h00, 0, 0, 4'd4, 3'd7, 1, 0, 0);
        check("snap_top_nib", led_a, 4'h1);

        // freeze holds stats, live event page
        step(8'hA5, 1, 32'hDEAD_0000, 4'd5, 3'd1, 1, 0, 1);
        step(8'h3C, 0, 0, 4'd6, 3'd0, 0, 0, 1);

        repeat (400) rand_step();

        // asynchronous reset mid-operation, released with a nonzero index
        repeat (5) step(8'hFF, 1, 32'h698, 4'd6, 3'd0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_led_sat", led_a, 4'h0);
        check("async_done_sat", {3'b0, done_a}, 4'h0);
        check("async_led_wrap", led_b, 4'h0);
        check("async_done_wrap", {3'b0, done_b}, 4'h0);
        model_reset();
        idx = 3'd3;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(8'h00, 0, 0, 4'd4, 3'd3, 0, 0, 0);
        step(8'h00, 0, 0, 4'd4, 3'd3, 0, 0, 0);
        repeat (100) rand_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
